// File: rtl/pipe_pkg.sv
// Shared pipeline-control types and constants.
// Register-address width, controller state encoding and the hard-wired zero register.
package pipe_pkg;

    localparam int RA_W = 5;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [RA_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the register a load in EX writes.
// Purely combinational; shared with the forwarding unit.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int RA_W_P = RA_W
) (
    input  logic [RA_W_P-1:0] id_rs_i,
    input  logic [RA_W_P-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic              ex_memread_i,
    input  logic [RA_W_P-1:0] ex_rd_i,
    output logic              lu_o
);

    logic rd_live;
    logic rs_hit;
    logic rt_hit;

    // Writes to the zero register are discarded, so they never create a dependency.
    assign rd_live = (ex_rd_i != RA_W_P'(ZERO_REG));
    assign rs_hit  = (ex_rd_i == id_rs_i);
    assign rt_hit  = id_uses_rt_i & (ex_rd_i == id_rt_i);
    assign lu_o    = ex_memread_i & rd_live & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing: load-use bubbles, branch squash, memory-wait freeze with deferred flush.
// Outputs are combinational (0-cycle); a pending memory access freezes every stage until ack or timeout.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int RA_W_P  = RA_W,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [RA_W_P-1:0] id_rs_i,
    input  logic [RA_W_P-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic              ex_memread_i,
    input  logic [RA_W_P-1:0] ex_rd_i,
    input  logic              branch_taken_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ack_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_flush_o,
    output logic              pipe_write_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              timeout_o
);

    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic              lu;
    logic              pc_w, ifid_w, ifid_fl, idex_fl, pipe_w;

    hazard_detect #(.RA_W_P(RA_W_P)) u_hazard_detect (
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_uses_rt_i (id_uses_rt_i),
        .ex_memread_i (ex_memread_i),
        .ex_rd_i      (ex_rd_i),
        .lu_o         (lu)
    );

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        flush_pend_d = flush_pend_q;
        timeout_d    = timeout_q;
        pc_w         = 1'b0;
        ifid_w       = 1'b0;
        ifid_fl      = 1'b0;
        idex_fl      = 1'b0;
        pipe_w       = 1'b0;
        case (state_q)
            RUN: begin
                if (dmem_req_i && !dmem_ack_i) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                    if (branch_taken_i) flush_pend_d = 1'b1;
                end else if (lu) begin
                    // The branch in ID is held with it and re-evaluated next cycle.
                    idex_fl = 1'b1;
                    pipe_w  = 1'b1;
                end else begin
                    pc_w         = 1'b1;
                    ifid_w       = 1'b1;
                    pipe_w       = 1'b1;
                    ifid_fl      = branch_taken_i | flush_pend_q;
                    flush_pend_d = 1'b0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack_i) begin
                    pc_w         = 1'b1;
                    ifid_w       = 1'b1;
                    pipe_w       = 1'b1;
                    ifid_fl      = flush_pend_q | branch_taken_i;
                    flush_pend_d = 1'b0;
                    state_d      = RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                    if (branch_taken_i) flush_pend_d = 1'b1;
                    // Abandon the access; any deferred flush survives into RUN.
                    if (wait_cnt_q == WC_W'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign pc_write_o   = rst_i & pc_w;
    assign ifid_write_o = rst_i & ifid_w;
    assign ifid_flush_o = rst_i & ifid_fl;
    assign idex_flush_o = rst_i & idex_fl;
    assign pipe_write_o = rst_i & pipe_w;
    assign stall_cnt_o  = stall_cnt_q;
    assign timeout_o    = timeout_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            timeout_q    <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            flush_pend_q <= flush_pend_d;
            timeout_q    <= timeout_d;
            if (!pc_w && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
